// File: rtl/hs_fork_join_unit_pkg.sv
// Shared constants and phase typedef for the handshake fork/join unit.
// Optional protocol checker is enabled with HS_PROTO_CHECK_EN.
package hs_pkg;

    localparam int HS_ERR_W    = 3;
    localparam int HS_ERR_FORK = 0;
    localparam int HS_ERR_JOIN = 1;
    localparam int HS_ERR_ACK  = 2;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_ACK  = 2'd2,
        HS_RTZ  = 2'd3
    } hs_phase_e;

    // Position in the 4-phase cycle implied by a req/ack pair.
    function automatic hs_phase_e hs_phase(input logic req, input logic ack);
        hs_phase_e ph;
        case ({req, ack})
            2'b00:   ph = HS_IDLE;
            2'b10:   ph = HS_REQ;
            2'b11:   ph = HS_ACK;
            default: ph = HS_RTZ;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/hs_fork_join_unit_if.sv
// Handshake bundle for hs_fork_join_unit: C-element vector, fork and join wires.
// proto_err exists only when HS_PROTO_CHECK_EN is defined; slave = the unit.
interface hs_fork_join_unit_if #(
    parameter int C_WIDTH = 1
);
    import hs_pkg::*;

    logic [C_WIDTH-1:0] c_a;
    logic [C_WIDTH-1:0] c_b;
    logic [C_WIDTH-1:0] c_out;

    logic f_e_req;
    logic f_e_ack;
    logic f_s1_req;
    logic f_s2_req;
    logic f_s1_ack;
    logic f_s2_ack;

    logic j_e1_req;
    logic j_e2_req;
    logic j_e1_ack;
    logic j_e2_ack;
    logic j_s_req;
    logic j_s_ack;

`ifdef HS_PROTO_CHECK_EN
    logic [HS_ERR_W-1:0] proto_err;

    modport slave (
        input  c_a, c_b, f_e_req, f_s1_ack, f_s2_ack, j_e1_req, j_e2_req, j_s_ack,
        output c_out, f_e_ack, f_s1_req, f_s2_req, j_e1_ack, j_e2_ack, j_s_req, proto_err
    );

    modport master (
        output c_a, c_b, f_e_req, f_s1_ack, f_s2_ack, j_e1_req, j_e2_req, j_s_ack,
        input  c_out, f_e_ack, f_s1_req, f_s2_req, j_e1_ack, j_e2_ack, j_s_req, proto_err
    );
`else
    modport slave (
        input  c_a, c_b, f_e_req, f_s1_ack, f_s2_ack, j_e1_req, j_e2_req, j_s_ack,
        output c_out, f_e_ack, f_s1_req, f_s2_req, j_e1_ack, j_e2_ack, j_s_req
    );

    modport master (
        output c_a, c_b, f_e_req, f_s1_ack, f_s2_ack, j_e1_req, j_e2_req, j_s_ack,
        input  c_out, f_e_ack, f_s1_req, f_s2_req, j_e1_ack, j_e2_ack, j_s_req
    );
`endif

endinterface

// File: rtl/hs_fork_join_unit_c_gate.sv
// Registered Muller C-element vector: each bit follows a/b when they agree, else holds.
// Latency 1 cycle; no backpressure, purely level-driven.
module c_gate #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);

    // Majority of (a, b, q) is exactly the set-when-both / clear-when-both / hold rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= INIT;
        end else begin
            q <= (a & b) | (q & (a | b));
        end
    end

endmodule

// File: rtl/hs_fork_join_unit.sv
// 4-phase handshake primitives: C-element vector, 1-to-2 fork, 2-to-1 join.
// Latency: C-outputs 1 cycle, req/ack pass-throughs 0 cycles; HS_PROTO_CHECK_EN adds sticky proto_err.
module hs_fork_join_unit
    import hs_pkg::*;
#(
    parameter int   C_WIDTH = 1,
    parameter logic C_INIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    hs_fork_join_unit_if.slave   hs
);

    c_gate #(
        .WIDTH (C_WIDTH),
        .INIT  ({C_WIDTH{C_INIT}})
    ) u_c_sec (
        .clk   (clk),
        .reset (reset),
        .a     (hs.c_a),
        .b     (hs.c_b),
        .q     (hs.c_out)
    );

    // Fork: request broadcast, acknowledge rendezvous.
    assign hs.f_s1_req = hs.f_e_req;
    assign hs.f_s2_req = hs.f_e_req;

    c_gate #(
        .WIDTH (1),
        .INIT  (1'b0)
    ) u_fork_ack (
        .clk   (clk),
        .reset (reset),
        .a     (hs.f_s1_ack),
        .b     (hs.f_s2_ack),
        .q     (hs.f_e_ack)
    );

    // Join: request rendezvous, acknowledge broadcast.
    assign hs.j_e1_ack = hs.j_s_ack;
    assign hs.j_e2_ack = hs.j_s_ack;

    c_gate #(
        .WIDTH (1),
        .INIT  (1'b0)
    ) u_join_req (
        .clk   (clk),
        .reset (reset),
        .a     (hs.j_e1_req),
        .b     (hs.j_e2_req),
        .q     (hs.j_s_req)
    );

`ifdef HS_PROTO_CHECK_EN
    logic                f_req_q;
    logic                j_e1_q;
    logic                j_e2_q;
    logic                j_ack_q;
    logic [HS_ERR_W-1:0] err_set;
    logic [HS_ERR_W-1:0] err_q;
    hs_phase_e           fork_ph;

    assign fork_ph = hs_phase(f_req_q, hs.f_e_ack);

    always_comb begin
        err_set = '0;
        // Request may only move when the previous phase has been acknowledged.
        err_set[HS_ERR_FORK] = (hs.f_e_req != f_req_q) &&
                               ((fork_ph == HS_REQ) || (fork_ph == HS_RTZ));
        err_set[HS_ERR_JOIN] = !hs.j_s_req &&
                               ((j_e1_q && !hs.j_e1_req && hs.j_e2_req) ||
                                (j_e2_q && !hs.j_e2_req && hs.j_e1_req));
        err_set[HS_ERR_ACK]  = (hs.j_s_ack != j_ack_q) && (j_ack_q == hs.j_s_req);
    end

    // History tracks live inputs during reset so release never looks like an edge.
    always_ff @(posedge clk) begin
        f_req_q <= hs.f_e_req;
        j_e1_q  <= hs.j_e1_req;
        j_e2_q  <= hs.j_e2_req;
        j_ack_q <= hs.j_s_ack;
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign hs.proto_err = err_q;
`endif

endmodule

// File: tb/tb_hs_fork_join_unit.sv
// Directed bench for hs_fork_join_unit with a per-cycle behavioural model and literal pins.
// Proto-checker comparisons are included when HS_PROTO_CHECK_EN is defined.
module tb_hs_fork_join_unit;

    localparam int   W    = 4;
    localparam logic INIT = 1'b1;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hs_fork_join_unit_if #(.C_WIDTH(W)) hs_if ();

    hs_fork_join_unit #(
        .C_WIDTH (W),
        .C_INIT  (INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hs_if)
    );

    // Behavioural model: state of each output as the rules describe it.
    logic [W-1:0] m_c;
    logic         m_fack;
    logic         m_jreq;
    logic [2:0]   m_err;
    logic         p_freq, p_e1, p_e2, p_ack;
    bit           started = 0;

    always @(posedge clk) begin
        logic [2:0] e;
        if (reset) begin
            m_c    = {W{INIT}};
            m_fack = 1'b0;
            m_jreq = 1'b0;
            m_err  = 3'b000;
        end else begin
            e    = 3'b000;
            e[0] = (hs_if.f_e_req != p_freq) && (p_freq != m_fack);
            e[1] = !m_jreq && ((p_e1 && !hs_if.j_e1_req && hs_if.j_e2_req) ||
                               (p_e2 && !hs_if.j_e2_req && hs_if.j_e1_req));
            e[2] = (hs_if.j_s_ack != p_ack) && (p_ack == m_jreq);
            m_err = m_err | e;
            for (int i = 0; i < W; i++)
                if (hs_if.c_a[i] == hs_if.c_b[i]) m_c[i] = hs_if.c_a[i];
            if (hs_if.f_s1_ack == hs_if.f_s2_ack) m_fack = hs_if.f_s1_ack;
            if (hs_if.j_e1_req == hs_if.j_e2_req) m_jreq = hs_if.j_e1_req;
        end
        p_freq  = hs_if.f_e_req;
        p_e1    = hs_if.j_e1_req;
        p_e2    = hs_if.j_e2_req;
        p_ack   = hs_if.j_s_ack;
        started = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_c_out",    32'(hs_if.c_out),    32'(m_c));
            chk("m_f_e_ack",  32'(hs_if.f_e_ack),  32'(m_fack));
            chk("m_j_s_req",  32'(hs_if.j_s_req),  32'(m_jreq));
            chk("m_f_s1_req", 32'(hs_if.f_s1_req), 32'(hs_if.f_e_req));
            chk("m_f_s2_req", 32'(hs_if.f_s2_req), 32'(hs_if.f_e_req));
            chk("m_j_e1_ack", 32'(hs_if.j_e1_ack), 32'(hs_if.j_s_ack));
            chk("m_j_e2_ack", 32'(hs_if.j_e2_ack), 32'(hs_if.j_s_ack));
`ifdef HS_PROTO_CHECK_EN
            chk("m_proto_err", 32'(hs_if.proto_err), 32'(m_err));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        hs_if.c_a      = '0;
        hs_if.c_b      = '0;
        hs_if.f_e_req  = 1'b0;
        hs_if.f_s1_ack = 1'b0;
        hs_if.f_s2_ack = 1'b0;
        hs_if.j_e1_req = 1'b0;
        hs_if.j_e2_req = 1'b0;
        hs_if.j_s_ack  = 1'b0;

        step(2);
        chk("rst_c_out",   32'(hs_if.c_out),   32'hF);
        chk("rst_f_e_ack", 32'(hs_if.f_e_ack), 32'h0);
        chk("rst_j_s_req", 32'(hs_if.j_s_req), 32'h0);
        reset = 1'b0;

        // Disagreeing inputs hold the reset value, agreement at 0 clears next cycle.
        hs_if.c_a = 4'hF; hs_if.c_b = 4'h0;
        step(1);
        chk("c_hold_init", 32'(hs_if.c_out), 32'hF);
        hs_if.c_a = 4'h0; hs_if.c_b = 4'h0;
        #1 chk("c_no_comb", 32'(hs_if.c_out), 32'hF);
        step(1);
        chk("c_clear", 32'(hs_if.c_out), 32'h0);

        hs_if.c_a = 4'hF; hs_if.c_b = 4'h0;
        step(5);
        chk("c_hold5", 32'(hs_if.c_out), 32'h0);
        hs_if.c_b = 4'hF;
        #1 chk("c_before_edge", 32'(hs_if.c_out), 32'h0);
        step(1);
        chk("c_set", 32'(hs_if.c_out), 32'hF);
        hs_if.c_a = 4'b1010; hs_if.c_b = 4'b0110;
        step(1);
        chk("c_mixed", 32'(hs_if.c_out), 32'hE);

        // Fork 4-phase
        hs_if.f_e_req = 1'b1;
        #1;
        chk("f_s1_req_pass", 32'(hs_if.f_s1_req), 32'h1);
        chk("f_s2_req_pass", 32'(hs_if.f_s2_req), 32'h1);
        hs_if.f_s1_ack = 1'b1;
        step(1);
        chk("f_ack_one", 32'(hs_if.f_e_ack), 32'h0);
        hs_if.f_s2_ack = 1'b1;
        step(1);
        chk("f_ack_both", 32'(hs_if.f_e_ack), 32'h1);
        hs_if.f_e_req  = 1'b0;
        hs_if.f_s1_ack = 1'b0;
        step(1);
        chk("f_ack_stag", 32'(hs_if.f_e_ack), 32'h1);
        hs_if.f_s2_ack = 1'b0;
        step(1);
        chk("f_ack_fall", 32'(hs_if.f_e_ack), 32'h0);

        // Join 4-phase
        hs_if.j_e1_req = 1'b1;
        step(1);
        chk("j_req_one", 32'(hs_if.j_s_req), 32'h0);
        hs_if.j_e2_req = 1'b1;
        step(1);
        chk("j_req_both", 32'(hs_if.j_s_req), 32'h1);
        hs_if.j_s_ack = 1'b1;
        #1;
        chk("j_e1_ack_pass", 32'(hs_if.j_e1_ack), 32'h1);
        chk("j_e2_ack_pass", 32'(hs_if.j_e2_ack), 32'h1);
        hs_if.j_e1_req = 1'b0;
        step(1);
        chk("j_req_hold", 32'(hs_if.j_s_req), 32'h1);
        hs_if.j_e2_req = 1'b0;
        step(1);
        chk("j_req_fall", 32'(hs_if.j_s_req), 32'h0);
        hs_if.j_s_ack = 1'b0;
        step(1);

        // Reset in the middle of both handshakes
        hs_if.f_e_req  = 1'b1;
        hs_if.f_s1_ack = 1'b1; hs_if.f_s2_ack = 1'b1;
        hs_if.j_e1_req = 1'b1; hs_if.j_e2_req = 1'b1;
        step(1);
        chk("mid_f_e_ack", 32'(hs_if.f_e_ack), 32'h1);
        chk("mid_j_s_req", 32'(hs_if.j_s_req), 32'h1);
        reset = 1'b1;
        step(1);
        chk("mid_rst_f_e_ack", 32'(hs_if.f_e_ack), 32'h0);
        chk("mid_rst_j_s_req", 32'(hs_if.j_s_req), 32'h0);
        chk("mid_rst_c_out",   32'(hs_if.c_out),   32'hF);
        reset = 1'b0;
        step(1);
        chk("post_f_e_ack", 32'(hs_if.f_e_ack), 32'h1);
        chk("post_j_s_req", 32'(hs_if.j_s_req), 32'h1);

        hs_if.f_e_req = 1'b0;
        step(1);
        hs_if.f_s1_ack = 1'b0; hs_if.f_s2_ack = 1'b0;
        hs_if.j_e1_req = 1'b0; hs_if.j_e2_req = 1'b0;
        step(2);
        chk("idle_f_e_ack", 32'(hs_if.f_e_ack), 32'h0);

`ifdef HS_PROTO_CHECK_EN
        chk("pe_clean", 32'(hs_if.proto_err), 32'h0);
        hs_if.f_e_req = 1'b1;
        step(1);
        hs_if.f_e_req = 1'b0;
        step(1);
        chk("pe_fork", 32'(hs_if.proto_err), 32'h1);
        step(3);
        chk("pe_sticky", 32'(hs_if.proto_err), 32'h1);
        hs_if.j_s_ack = 1'b1;
        step(1);
        chk("pe_ack", 32'(hs_if.proto_err), 32'h5);
        hs_if.j_e1_req = 1'b1;
        step(1);
        hs_if.j_e1_req = 1'b0;
        step(1);
        chk("pe_join_alone_ok", 32'(hs_if.proto_err), 32'h5);
        reset = 1'b1;
        step(1);
        chk("pe_reset", 32'(hs_if.proto_err), 32'h0);
        reset = 1'b0;
        hs_if.j_s_ack = 1'b0;
        step(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hs_fork_join_unit.md
Name: hs_fork_join_unit

Overview:
- Clocked, synthesizable set of 4-phase handshake control primitives for the asynchronous-style pipeline controller.
- Contains three independent sections:
  - a vector Muller C-element (stage request generator);
  - a 1-to-2 fork (request broadcast, acknowledge rendezvous);
  - a 2-to-1 join (request rendezvous, acknowledge broadcast).
- Used for fetch → decode/GPR split → execute merge sequencing.

Parameters:
- C_WIDTH, 1, number of parallel C-elements in the C-element section (bitwise independent).
- C_INIT, 1'b0, reset value of every C-element output bit (replicated across C_WIDTH).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- c_a  input  C_WIDTH  C-element input A.
- c_b  input  C_WIDTH  C-element input B.
- c_out  output  C_WIDTH  C-element output.
- f_e_req  input  1  fork upstream request.
- f_e_ack  output  1  fork upstream acknowledge.
- f_s1_req  output  1  fork branch-1 request.
- f_s2_req  output  1  fork branch-2 request.
- f_s1_ack  input  1  fork branch-1 acknowledge.
- f_s2_ack  input  1  fork branch-2 acknowledge.
- j_e1_req  input  1  join input-1 request.
- j_e2_req  input  1  join input-2 request.
- j_e1_ack  output  1  join input-1 acknowledge.
- j_e2_ack  output  1  join input-2 acknowledge.
- j_s_req  output  1  join downstream request.
- j_s_ack  input  1  join downstream acknowledge.
- proto_err  output  3  sticky protocol error flags; present only with HS_PROTO_CHECK_EN.

Behaviour:
- C-element rule, per bit, registered:
  - if a==b, the output takes that value on the next rising clk;
  - otherwise it holds its value.
  - Latency is exactly 1 cycle from inputs agreeing to the output changing.
- Reset: c_out=C_INIT, f_e_ack=0, j_s_req=0, proto_err=0. Reset is synchronous, has priority over all updates, and may be applied mid-handshake with no glitch beyond the reset values.
- Fork:
  - f_s1_req = f_s2_req = f_e_req, combinational pass-through with 0-cycle latency.
  - f_e_ack = C(f_s1_ack, f_s2_ack), registered.
  - f_e_ack rises only once both branch acks are 1, and falls only once both are 0.
  - A single branch ack toggling alone leaves f_e_ack unchanged.
- Join:
  - j_s_req = C(j_e1_req, j_e2_req), registered.
  - j_e1_ack = j_e2_ack = j_s_ack, combinational pass-through.
  - j_s_req rises only once both input requests are 1, and falls only once both are 0.
- Simultaneous events: both inputs of a C-element changing to the same value in one cycle → output updates the next cycle.
- Opposite changes → hold.
- No internal clock-domain crossing; all inputs are synchronous to clk.

Optional Feature:
- Macro: HS_PROTO_CHECK_EN.
- Defined: proto_err sticky bits, set one cycle after the violation, cleared only by reset.
  - bit0: f_e_req changes while f_e_req != f_e_ack (fork request withdrawn/reissued before ack).
  - bit1: j_e1_req or j_e2_req falls while j_s_req=0 and the other request is 1 (join input withdrawn before rendezvous).
  - bit2: j_s_ack changes while j_s_ack == j_s_req (downstream ack without new request phase).
- Undefined: proto_err port absent; no checker logic.

Decomposition:
- Package hs_pkg:
  - constant HS_ERR_W=3;
  - localparams HS_ERR_FORK=0, HS_ERR_JOIN=1, HS_ERR_ACK=2;
  - typedef hs_phase_e {HS_IDLE, HS_REQ, HS_ACK, HS_RTZ} for checker tracking.
- One sub-module: c_gate (parameterized-width registered C-element with reset value), instantiated three times: c-section, fork ack, join req.

Test Plan:
- Reset with C_INIT=1: reset=1 for 2 cycles → c_out=1, f_e_ack=0, j_s_req=0. Then c_a=1, c_b=0 → c_out stays 1. Then c_a=0, c_b=0 → c_out=0 one cycle later.
- C-element hold: c_a=1, c_b=0 for 5 cycles from c_out=0 → c_out=0. Set c_b=1 → c_out=1 exactly 1 cycle later.
- Fork full 4-phase:
  - f_e_req=1 → f_s1_req=f_s2_req=1 same cycle;
  - f_s1_ack=1 only → f_e_ack=0;
  - f_s2_ack=1 → f_e_ack=1 next cycle;
  - f_e_req=0, acks to 0 staggered → f_e_ack falls one cycle after the last ack falls.
- Join full 4-phase:
  - j_e1_req=1, j_e2_req=0 → j_s_req=0;
  - j_e2_req=1 → j_s_req=1 next cycle;
  - j_s_ack=1 → j_e1_ack=j_e2_ack=1 same cycle;
  - reqs to 0 → j_s_req=0 one cycle after both are 0.
- Reset mid-handshake: f_e_ack=1, j_s_req=1, then reset=1 for 1 cycle → both 0 next cycle. Outputs recompute from inputs afterwards.
- With HS_PROTO_CHECK_EN: f_e_req 0→1→0 while f_e_ack stays 0 → proto_err[0]=1, stays set until reset.
